frame_column_writer: RTL and testbench
======================================

// Module: frame_column_writer
// PURPOSE
//  Source end of the column configuration interface. Accepts a word stream (header + data)
//  over a valid/ready handshake and drives FrameData/FrameStrobe into the bottom tile of a
//  fabric column, which buffers them on to the column's other tiles.
//  Each transaction writes one frame: FrameData is held stable and one FrameStrobe bit pulses.
// PARAMETERS
//  MaxFramesPerCol  20  number of FrameStrobe lines (frames per column), 1..256
//  FrameBitsPerRow  32  FrameData width, >=16
//  StrobeCycles     2   cycles FrameStrobe is held high per frame, >=1
// PORTS
//  UserCLK        in   1                clock; all logic rising-edge
//  Reset          in   1                asynchronous, active-high reset
//  WriteData      in   FrameBitsPerRow  stream word (header or frame data)
//  WriteValid     in   1                WriteData valid
//  WriteReady     out  1                block accepts a word this cycle
//  ErrClear       in   1                clears ErrSticky
//  FrameData      out  FrameBitsPerRow  frame data to column, registered
//  FrameStrobe    out  MaxFramesPerCol  one-hot frame strobe, registered
//  Busy           out  1                transaction in progress (state != IDLE)
//  ErrSticky      out  1                protocol error seen since last clear
//  FramesWritten  out  16               count of completed strobes, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE, FrameData=0, FrameStrobe=0, ErrSticky=0, FramesWritten=0, WriteReady=1.
//  Reset is asynchronous: asserting it mid-strobe drops FrameStrobe to 0 immediately.
//  Handshake: word transfers on the rising edge where WriteValid && WriteReady.
//   WriteReady is combinational from state: 1 in IDLE, WAIT_DATA, SKIP; 0 in STROBE, HOLD.
//   WriteData is sampled only on a transfer; WriteValid may stay high across states.
//  Header: WriteData[FrameBitsPerRow-1 -: 8] == 8'hFA is the marker; WriteData[7:0] is frame idx.
//  FSM:
//   IDLE: header transfer, valid marker, idx<MaxFramesPerCol -> latch idx, WAIT_DATA.
//         header, valid marker, idx>=MaxFramesPerCol -> ErrSticky=1, SKIP.
//         header, bad marker -> ErrSticky=1, word dropped, stay IDLE.
//   WAIT_DATA: data transfer -> FrameData<=WriteData, cnt<=StrobeCycles-1, STROBE.
//   SKIP: next transfer discarded (the frame's data word) -> IDLE.
//   STROBE: FrameStrobe[idx]=1, others 0; cnt decrements; at cnt==0 -> HOLD and
//           FramesWritten increments on that same edge.
//   HOLD: one cycle, FrameStrobe=0, FrameData unchanged (hold time) -> IDLE.
//  Latency: data word accepted at edge t -> FrameData valid and strobe high from t+1
//   through t+StrobeCycles; HOLD at t+StrobeCycles+1; next header accepted at t+StrobeCycles+2
//   at the earliest.
//  FrameData retains its last written value after the transaction (not cleared).
//  FrameStrobe is never multi-hot; outside STROBE it is all-zero.
//  ErrClear and a new error on the same edge: error wins, ErrSticky stays 1.
//  Errors never abort a strobe already in progress, and never change FrameData/FrameStrobe.
// TESTING
//  1 Reset, send 0xFA000003 then 0xDEADBEEF back-to-back -> FrameData=0xDEADBEEF,
//    FrameStrobe=20'h00008 for exactly 2 cycles, then 0; FramesWritten=1; WriteReady=0 for 3 cycles.
//  2 Header 0xFA000014 (idx 20), then 0x12345678 -> ErrSticky=1, no strobe, FrameData unchanged,
//    returns to IDLE after the data word; next valid frame is written normally.
//  3 Header 0x11000001 -> dropped, ErrSticky=1, stays IDLE; ErrClear pulse -> ErrSticky=0;
//    ErrClear on the same cycle as a bad header -> ErrSticky stays 1.
//  4 Assert Reset asynchronously during STROBE for idx 19 -> FrameStrobe=0 and FrameData=0
//    before the next clock edge; FramesWritten=0; Busy=0.
//  5 WriteValid held high with 4 frames queued (idx 0,1,2,19) -> each strobe one-hot, in order,
//    no words lost or duplicated; FramesWritten=4.
//  6 Preload FramesWritten=0xFFFF via 65535 frames (or force) -> next frame wraps it to 0x0000.

Source files
------------

// File: rtl/frame_column_writer.sv
// frame_column_writer: source end of a fabric column's configuration path.
// Takes a header+data word stream over valid/ready and writes one frame per
// transaction: FrameData is held stable while a single FrameStrobe bit pulses
// for StrobeCycles cycles, followed by one hold cycle with the strobe low.
module frame_column_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 2
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic [FrameBitsPerRow-1:0] WriteData,
  input  logic                       WriteValid,
  output logic                       WriteReady,
  input  logic                       ErrClear,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Busy,
  output logic                       ErrSticky,
  output logic [15:0]                FramesWritten
);

  // Strobe countdown only needs to hold StrobeCycles-1.
  localparam int CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SKIP,
    STROBE,
    HOLD
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 idx_q, idx_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
  logic [MaxFramesPerCol-1:0] frame_strobe_q, frame_strobe_d;
  logic                       err_q, err_d;
  logic [15:0]                frames_written_q, frames_written_d;

  logic                       xfer;
  logic                       hdr_marker_ok;
  logic                       hdr_idx_ok;
  logic                       err_event;
  logic [MaxFramesPerCol-1:0] idx_onehot;

  // Header fields: marker byte on top, frame index in the low byte.
  assign hdr_marker_ok = (WriteData[FrameBitsPerRow-1 -: 8] == 8'hFA);
  assign hdr_idx_ok    = ({1'b0, WriteData[7:0]} < 9'(MaxFramesPerCol));

  // Ready depends only on state, so a word never waits on itself.
  assign WriteReady = (state_q == IDLE) || (state_q == WAIT_DATA) || (state_q == SKIP);
  assign xfer       = WriteValid && WriteReady;

  // Decode the latched frame index into the one-hot strobe pattern.
  for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_q == 8'(gi));
  end

  // Next-state logic and register updates for the frame transaction.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    frame_data_d     = frame_data_q;
    frame_strobe_d   = frame_strobe_q;
    frames_written_d = frames_written_q;
    err_event        = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!hdr_marker_ok) begin
            err_event = 1'b1;              // bad marker: word is dropped
          end else if (hdr_idx_ok) begin
            idx_d   = WriteData[7:0];
            state_d = WAIT_DATA;
          end else begin
            err_event = 1'b1;              // index out of range: swallow its data word
            state_d   = SKIP;
          end
        end
      end
      WAIT_DATA: begin
        if (xfer) begin
          frame_data_d   = WriteData;
          frame_strobe_d = idx_onehot;
          cnt_d          = CntW'(StrobeCycles - 1);
          state_d        = STROBE;
        end
      end
      SKIP: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          frame_strobe_d   = '0;
          frames_written_d = frames_written_q + 16'd1;
          state_d          = HOLD;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      HOLD: begin
        state_d = IDLE;                    // data stays put one more cycle for hold time
      end
      default: begin
        frame_strobe_d = '0;
        state_d        = IDLE;
      end
    endcase

    // A fresh error beats a simultaneous clear.
    err_d = err_event || (err_q && !ErrClear);
  end

  // State and output registers; reset clears the strobe immediately.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      frame_data_q     <= '0;
      frame_strobe_q   <= '0;
      err_q            <= 1'b0;
      frames_written_q <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      frame_data_q     <= frame_data_d;
      frame_strobe_q   <= frame_strobe_d;
      err_q            <= err_d;
      frames_written_q <= frames_written_d;
    end
  end

  assign FrameData     = frame_data_q;
  assign FrameStrobe   = frame_strobe_q;
  assign Busy          = (state_q != IDLE);
  assign ErrSticky     = err_q;
  assign FramesWritten = frames_written_q;

endmodule

// File: tb/tb_frame_column_writer.sv
// Bench for frame_column_writer: directed word streams, a transaction-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_frame_column_writer;

  localparam int M = 20;
  localparam int W = 32;
  localparam int S = 2;

  logic          UserCLK    = 1'b0;
  logic          Reset      = 1'b1;
  logic [W-1:0]  WriteData  = '0;
  logic          WriteValid = 1'b0;
  logic          ErrClear   = 1'b0;
  logic          WriteReady;
  logic [W-1:0]  FrameData;
  logic [M-1:0]  FrameStrobe;
  logic          Busy;
  logic          ErrSticky;
  logic [15:0]   FramesWritten;

  frame_column_writer #(
    .MaxFramesPerCol(M),
    .FrameBitsPerRow(W),
    .StrobeCycles(S)
  ) dut (
    .UserCLK(UserCLK),
    .Reset(Reset),
    .WriteData(WriteData),
    .WriteValid(WriteValid),
    .WriteReady(WriteReady),
    .ErrClear(ErrClear),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .Busy(Busy),
    .ErrSticky(ErrSticky),
    .FramesWritten(FramesWritten)
  );

  always #5 UserCLK = ~UserCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 wants header, 1 wants data, 2 discards one word, 3 writing frame.
  // left: cycles the writer still refuses words after a data word (S strobe + 1 hold).
  int          m_mode  = 0;
  int          m_left  = 0;
  logic [7:0]  m_idx   = '0;
  logic [31:0] m_data  = '0;
  logic        m_err   = 1'b0;
  logic        m_enew  = 1'b0;
  logic [15:0] m_count = '0;
  bit          m_force = 1'b0;

  initial forever begin
    @(posedge UserCLK or posedge Reset);
    if (Reset) begin
      m_mode = 0; m_left = 0; m_idx = '0; m_data = '0; m_err = 1'b0; m_count = '0;
    end else begin
      m_enew = 1'b0;
      if (m_force) m_count = 16'hFFFF;
      if (m_mode == 3) begin
        if (m_left == 2) m_count = m_count + 16'd1;   // last strobe cycle ends here
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end else if (WriteValid) begin
        if (m_mode == 0) begin
          if (WriteData[31:24] != 8'hFA) m_enew = 1'b1;
          else if (int'(WriteData[7:0]) < M) begin m_idx = WriteData[7:0]; m_mode = 1; end
          else begin m_enew = 1'b1; m_mode = 2; end
        end else if (m_mode == 1) begin
          m_data = WriteData; m_mode = 3; m_left = S + 1;
        end else begin
          m_mode = 0;
        end
      end
      m_err = m_enew || (m_err && !ErrClear);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           chk_en = 1'b0;
  int           sq[$];
  logic [M-1:0] prev_strobe = '0;

  initial forever begin
    logic [M-1:0] es;
    @(negedge UserCLK);
    if (chk_en) begin
      es = (m_mode == 3 && m_left >= 2) ? (20'd1 << m_idx) : 20'd0;
      chk("ready",  32'(WriteReady),    32'(m_mode != 3));
      chk("busy",   32'(Busy),          32'(m_mode != 0));
      chk("data",   FrameData,          m_data);
      chk("strobe", 32'(FrameStrobe),   32'(es));
      chk("err",    32'(ErrSticky),     32'(m_err));
      chk("count",  32'(FramesWritten), 32'(m_count));
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        for (int i = 0; i < M; i++) if (FrameStrobe[i]) sq.push_back(i);
      end
      prev_strobe = FrameStrobe;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge just after the word transferred.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    WriteData  = w;
    WriteValid = 1'b1;
    while (WriteReady !== 1'b1 && n < 50) begin
      @(negedge UserCLK);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h not accepted, got ready=%b required ready=1", w, WriteReady);
    end
    @(negedge UserCLK);
  endtask

  task automatic idle(input int n);
    WriteValid = 1'b0;
    repeat (n) @(negedge UserCLK);
  endtask

  logic [31:0] t5_words [8];
  int          t5_idx   [4];

  initial begin
    t5_words = '{32'hFA000000, 32'hD0D0D0D0, 32'hFA000001, 32'hD1D1D1D1,
                 32'hFA000002, 32'hD2D2D2D2, 32'hFA000013, 32'hD3D3D3D3};
    t5_idx   = '{0, 1, 2, 19};

    repeat (3) @(negedge UserCLK);
    chk("rst_strobe", 32'(FrameStrobe),   32'h0);
    chk("rst_data",   FrameData,          32'h0);
    chk("rst_ready",  32'(WriteReady),    32'h1);
    chk("rst_count",  32'(FramesWritten), 32'h0);
    Reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge UserCLK);

    // 1: basic frame, idx 3
    send_word(32'hFA000003);
    send_word(32'hDEADBEEF);
    WriteValid = 1'b0;
    chk("t1_strobe_c1", 32'(FrameStrobe), 32'h00008);
    chk("t1_data",      FrameData,        32'hDEADBEEF);
    chk("t1_ready_c1",  32'(WriteReady),  32'h0);
    @(negedge UserCLK);
    chk("t1_strobe_c2", 32'(FrameStrobe), 32'h00008);
    chk("t1_ready_c2",  32'(WriteReady),  32'h0);
    @(negedge UserCLK);
    chk("t1_strobe_hold", 32'(FrameStrobe), 32'h0);
    chk("t1_ready_hold",  32'(WriteReady),  32'h0);
    chk("t1_busy_hold",   32'(Busy),        32'h1);
    @(negedge UserCLK);
    chk("t1_ready_idle",  32'(WriteReady),    32'h1);
    chk("t1_count",       32'(FramesWritten), 32'h1);

    // 2: out-of-range index swallows its data word
    send_word(32'hFA000014);
    send_word(32'h12345678);
    WriteValid = 1'b0;
    chk("t2_err",    32'(ErrSticky),   32'h1);
    chk("t2_busy",   32'(Busy),        32'h0);
    chk("t2_data",   FrameData,        32'hDEADBEEF);
    chk("t2_strobe", 32'(FrameStrobe), 32'h0);
    send_word(32'hFA000005);
    send_word(32'h0BADF00D);
    WriteValid = 1'b0;
    chk("t2_strobe5", 32'(FrameStrobe), 32'h00020);
    idle(3);
    chk("t2_count", 32'(FramesWritten), 32'h2);

    // 3: bad marker and error clear
    ErrClear = 1'b1;
    @(negedge UserCLK);
    ErrClear = 1'b0;
    chk("t3_clr0", 32'(ErrSticky), 32'h0);
    send_word(32'h11000001);
    WriteValid = 1'b0;
    chk("t3_err",  32'(ErrSticky), 32'h1);
    chk("t3_busy", 32'(Busy),      32'h0);
    ErrClear = 1'b1;
    @(negedge UserCLK);
    ErrClear = 1'b0;
    chk("t3_clr1", 32'(ErrSticky), 32'h0);
    ErrClear = 1'b1;
    send_word(32'h11000001);
    ErrClear   = 1'b0;
    WriteValid = 1'b0;
    chk("t3_err_wins", 32'(ErrSticky), 32'h1);

    // 4: asynchronous reset mid-strobe
    send_word(32'hFA000013);
    send_word(32'hCAFEF00D);
    WriteValid = 1'b0;
    chk("t4_strobe19", 32'(FrameStrobe), 32'h80000);
    @(posedge UserCLK);
    #2 Reset = 1'b1;
    #1;
    chk("t4_strobe", 32'(FrameStrobe),   32'h0);
    chk("t4_data",   FrameData,          32'h0);
    chk("t4_count",  32'(FramesWritten), 32'h0);
    chk("t4_busy",   32'(Busy),          32'h0);
    @(negedge UserCLK);
    Reset = 1'b0;
    @(negedge UserCLK);

    // 5: streamed frames with valid held high
    sq.delete();
    for (int i = 0; i < 8; i++) send_word(t5_words[i]);
    idle(4);
    chk("t5_count", 32'(FramesWritten), 32'h4);
    chk("t5_data",  FrameData,          32'hD3D3D3D3);
    chk("t5_nstrb", 32'(sq.size()),     32'h4);
    for (int i = 0; i < 4; i++) chk("t5_order", 32'(sq[i]), 32'(t5_idx[i]));

    // 6: counter wrap
    force dut.frames_written_d = 16'hFFFF;
    m_force = 1'b1;
    @(negedge UserCLK);
    release dut.frames_written_d;
    m_force = 1'b0;
    chk("t6_preload", 32'(FramesWritten), 32'hFFFF);
    send_word(32'hFA000007);
    send_word(32'h5A5A5A5A);
    WriteValid = 1'b0;
    chk("t6_strobe", 32'(FrameStrobe), 32'h00080);
    idle(4);
    chk("t6_wrap", 32'(FramesWritten), 32'h0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
